spi_frame_counter: RTL and testbench

//  Two-level SPI sequencing counter: counts bits within a word and words within a frame.

---
 rtl/spi_frame_counter_pkg.sv | 18 +
 rtl/spi_tick_counter.sv | 29 ++
 rtl/spi_frame_counter.sv | 155 +++++++++++++++
 tb/tb_spi_frame_counter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_frame_counter_pkg.sv
// Shared types and width helpers for the SPI frame counter slice.
package spi_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2
   } spi_frm_state_t;

   localparam int unsigned SPI_MAX_BITS_DEF  = 16;
   localparam int unsigned SPI_MAX_WORDS_DEF = 8;
   localparam int unsigned SPI_MAX_GAP_DEF   = 4;

   function automatic int unsigned spi_cnt_w(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/spi_tick_counter.sv
// Tick-driven wrap counter: counts 0..i_len, wraps to 0 and flags the wrap tick.
module spi_tick_counter #(
   parameter int unsigned W = 4
) (
   input  logic         i_clk,
   input  logic         i_reset,
   input  logic         i_tick,
   input  logic         i_clear,
   input  logic [W-1:0] i_len,
   output logic [W-1:0] o_cnt,
   output logic         o_wrap
);

   logic [W-1:0] cnt_q;

   assign o_wrap = i_tick && !i_clear && (cnt_q == i_len);
   assign o_cnt  = cnt_q;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         cnt_q <= '0;
      end else if (i_clear) begin
         cnt_q <= '0;
      end else if (i_tick) begin
         cnt_q <= o_wrap ? '0 : cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/spi_frame_counter.sv
// Two-level SPI bit/word sequencing counter with start/abort control.
// Optional inter-word gap enabled by defining SPI_FRAME_CNT_GAP_EN.
module spi_frame_counter
   import spi_pkg::*;
#(
   parameter int unsigned MAX_BITS  = SPI_MAX_BITS_DEF,
   parameter int unsigned MAX_WORDS = SPI_MAX_WORDS_DEF,
   parameter int unsigned MAX_GAP   = SPI_MAX_GAP_DEF,
   parameter int unsigned BIT_W     = spi_cnt_w(MAX_BITS),
   parameter int unsigned WORD_W    = spi_cnt_w(MAX_WORDS)
`ifdef SPI_FRAME_CNT_GAP_EN
   , parameter int unsigned GAP_W   = spi_cnt_w(MAX_GAP)
`endif
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_sclk_enable,
   input  logic              i_start,
   input  logic              i_abort,
   input  logic [BIT_W-1:0]  i_bit_len,
   input  logic [WORD_W-1:0] i_word_len,
`ifdef SPI_FRAME_CNT_GAP_EN
   input  logic [GAP_W-1:0]  i_gap_len,
`endif
   output logic [BIT_W-1:0]  o_bit_cnt,
   output logic [WORD_W-1:0] o_word_cnt,
   output logic              o_busy,
   output logic              o_last_bit,
   output logic              o_word_done,
   output logic              o_frame_done
`ifdef SPI_FRAME_CNT_GAP_EN
   , output logic            o_gap
`endif
);

   if (MAX_BITS < 2 || MAX_WORDS < 2 || MAX_GAP < 2) begin : g_param_check
      $error("spi_frame_counter: MAX_BITS, MAX_WORDS and MAX_GAP must be >= 2");
   end

   spi_frm_state_t    state_q, state_d;
   logic              latch_en;
   logic [BIT_W-1:0]  bit_len_q;
   logic [WORD_W-1:0] word_len_q;
   logic              word_done_q, frame_done_q;
   logic              shift_tick, bit_wrap, word_wrap;
   logic              gap_en, gap_wrap;

   assign shift_tick = (state_q == SHIFT) && i_sclk_enable && !i_abort;

   spi_tick_counter #(.W(BIT_W)) u_bit_cnt (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_tick  (shift_tick),
      .i_clear (i_abort),
      .i_len   (bit_len_q),
      .o_cnt   (o_bit_cnt),
      .o_wrap  (bit_wrap)
   );

   // Word counter advances on the bit-counter wrap, so it moves exactly once per word.
   spi_tick_counter #(.W(WORD_W)) u_word_cnt (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_tick  (bit_wrap),
      .i_clear (i_abort),
      .i_len   (word_len_q),
      .o_cnt   (o_word_cnt),
      .o_wrap  (word_wrap)
   );

`ifdef SPI_FRAME_CNT_GAP_EN
   logic [GAP_W-1:0] gap_len_q;
   logic [GAP_W-1:0] gap_cnt_unused;
   logic             gap_tick;

   assign gap_tick = (state_q == GAP) && i_sclk_enable && !i_abort;
   assign gap_en   = (gap_len_q != '0);
   assign o_gap    = (state_q == GAP);

   // GAP is only entered with gap_len != 0, so gap_len-1 never underflows in use.
   spi_tick_counter #(.W(GAP_W)) u_gap_cnt (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_tick  (gap_tick),
      .i_clear (i_abort),
      .i_len   (gap_len_q - 1'b1),
      .o_cnt   (gap_cnt_unused),
      .o_wrap  (gap_wrap)
   );

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         gap_len_q <= '0;
      end else if (latch_en) begin
         gap_len_q <= i_gap_len;
      end
   end
`else
   assign gap_en   = 1'b0;
   assign gap_wrap = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      latch_en = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_start) begin
               state_d  = SHIFT;
               latch_en = !i_abort;
            end
         end
         SHIFT: begin
            if (word_wrap) begin
               state_d = IDLE;
            end else if (bit_wrap && gap_en) begin
               state_d = GAP;
            end
         end
         GAP: begin
            if (gap_wrap) begin
               state_d = SHIFT;
            end
         end
         default: state_d = IDLE;
      endcase
      if (i_abort) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q      <= IDLE;
         bit_len_q    <= '0;
         word_len_q   <= '0;
         word_done_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         word_done_q  <= bit_wrap;
         frame_done_q <= word_wrap;
         if (latch_en) begin
            bit_len_q  <= i_bit_len;
            word_len_q <= i_word_len;
         end
      end
   end

   assign o_busy       = (state_q != IDLE);
   assign o_last_bit   = (state_q == SHIFT) && (o_bit_cnt == bit_len_q);
   assign o_word_done  = word_done_q;
   assign o_frame_done = frame_done_q;

endmodule

// File: tb/tb_spi_frame_counter.sv
// Randomized self-checking bench for spi_frame_counter against a tick-position model.
module tb_spi_frame_counter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tick = 1'b0, start = 1'b0, abort = 1'b0;
   logic [3:0] bit_len = '0;
   logic [2:0] word_len = '0;
   logic [1:0] gap_len = '0;
   logic [3:0] o_bit_cnt;
   logic [2:0] o_word_cnt;
   logic       o_busy, o_last_bit, o_word_done, o_frame_done, dut_gap;

   int n_checks = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   spi_frame_counter dut (
      .i_clk         (clk),
      .i_reset       (rst_n),
      .i_sclk_enable (tick),
      .i_start       (start),
      .i_abort       (abort),
      .i_bit_len     (bit_len),
      .i_word_len    (word_len),
`ifdef SPI_FRAME_CNT_GAP_EN
      .i_gap_len     (gap_len),
`endif
      .o_bit_cnt     (o_bit_cnt),
      .o_word_cnt    (o_word_cnt),
      .o_busy        (o_busy),
      .o_last_bit    (o_last_bit),
      .o_word_done   (o_word_done),
      .o_frame_done  (o_frame_done)
`ifdef SPI_FRAME_CNT_GAP_EN
      , .o_gap       (dut_gap)
`endif
   );

`ifndef SPI_FRAME_CNT_GAP_EN
   assign dut_gap = 1'b0;
`endif

   // Model: a frame is a sequence of T ticks; outputs are decoded from the tick count n.
   bit m_active;
   int m_n, m_b, m_w, m_g;
   bit m_wd, m_fd;

   function automatic logic [11:0] dut_out();
      return {o_busy, o_last_bit, o_word_done, o_frame_done, dut_gap, o_bit_cnt, o_word_cnt};
   endfunction

   function automatic logic [11:0] model_out();
      int p, q, r;
      logic [3:0] b;
      logic [2:0] w;
      logic g, lb;
      b = '0; w = '0; g = 1'b0; lb = 1'b0;
      if (m_active) begin
         p = m_b + 1 + m_g;
         q = m_n / p;
         r = m_n % p;
         if (r <= m_b) begin
            b = 4'(r); w = 3'(q); lb = (r == m_b);
         end else begin
            w = 3'(q + 1); g = 1'b1;
         end
      end
      return {logic'(m_active), lb, logic'(m_wd), logic'(m_fd), g, b, w};
   endfunction

   task automatic model_reset();
      m_active = 0; m_n = 0; m_wd = 0; m_fd = 0;
      m_b = 0; m_w = 0; m_g = 0;
   endtask

   task automatic model_step(input bit tk, input bit st, input bit ab);
      int p, total;
      m_wd = 0; m_fd = 0;
      if (ab) begin
         m_active = 0; m_n = 0;
      end else if (!m_active) begin
         if (st) begin
            m_active = 1; m_n = 0;
            m_b = int'(bit_len); m_w = int'(word_len);
`ifdef SPI_FRAME_CNT_GAP_EN
            m_g = int'(gap_len);
`else
            m_g = 0;
`endif
         end
      end else if (tk) begin
         p = m_b + 1 + m_g;
         total = (m_b + 1) * (m_w + 1) + m_w * m_g;
         m_n++;
         m_wd = (m_n >= m_b + 1) && (((m_n - m_b - 1) % p) == 0);
         if (m_n == total) begin
            m_fd = 1; m_active = 0; m_n = 0;
         end
      end
   endtask

   task automatic cycle(input bit tk, input bit st, input bit ab);
      tick = tk; start = st; abort = ab;
      @(posedge clk);
      model_step(tk, st, ab);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b1; tick = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (dut_out() !== 12'h000) $display("FAIL reset_state got=%h exp=%h", dut_out(), 12'h000);
      else n_pass++;
      start = 1'b0; tick = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      cycle(1, 0, 0);
      n_checks++;
      if (dut_out() !== model_out()) $display("FAIL reset_release got=%h exp=%h", dut_out(), model_out());
      else n_pass++;
   endtask

   task automatic test_single_word();
      int busy_n = 0, fd_n = 0, fd_at = -1;
      bit_len = 4'd7; word_len = 3'd0; gap_len = 2'd0;
      cycle(0, 1, 0);
      if (o_busy) busy_n++;
      for (int i = 0; i < 10; i++) begin
         cycle(1, 0, 0);
         n_checks++;
         if (dut_out() !== model_out()) $display("FAIL single_word i=%0d got=%h exp=%h", i, dut_out(), model_out());
         else n_pass++;
         if (o_busy) busy_n++;
         if (o_frame_done) begin fd_n++; fd_at = i + 1; end
      end
      n_checks++;
      if (busy_n !== 8 || fd_n !== 1 || fd_at !== 8)
         $display("FAIL single_word_counts busy=%0d fd=%0d at=%0d exp busy=8 fd=1 at=8", busy_n, fd_n, fd_at);
      else n_pass++;
   endtask

   task automatic test_multi_word();
      int wd_n = 0, fd_n = 0, fd_at = -1, ticks = 0;
      int seq[$];
      int exp_seq[4] = '{0, 1, 2, 0};
      bit seq_ok;
      bit_len = 4'd3; word_len = 3'd2;
      cycle(0, 1, 0);
      seq.push_back(int'(o_word_cnt));
      for (int i = 0; i < 45; i++) begin
         cycle(i % 3 == 2, 0, 0);
         if (i % 3 == 2) ticks++;
         n_checks++;
         if (dut_out() !== model_out()) $display("FAIL multi_word i=%0d got=%h exp=%h", i, dut_out(), model_out());
         else n_pass++;
         if (o_word_done) wd_n++;
         if (o_frame_done) begin fd_n++; fd_at = ticks; end
         if (int'(o_word_cnt) != seq[$]) seq.push_back(int'(o_word_cnt));
      end
      seq_ok = (seq.size() == 4);
      for (int k = 0; k < 4 && seq_ok; k++) if (seq[k] != exp_seq[k]) seq_ok = 0;
      n_checks++;
      if (wd_n !== 3 || fd_n !== 1 || fd_at !== 12 || !seq_ok)
         $display("FAIL multi_word_counts wd=%0d fd=%0d at=%0d seq_len=%0d exp wd=3 fd=1 at=12 seq=0,1,2,0",
                  wd_n, fd_n, fd_at, seq.size());
      else n_pass++;
   endtask

   task automatic test_abort();
      int fd_n = 0;
      bit_len = 4'd7; word_len = 3'd0;
      cycle(0, 1, 0);
      repeat (5) cycle(1, 0, 0);
      cycle(1, 1, 1);
      n_checks++;
      if (dut_out() !== 12'h000) $display("FAIL abort_state got=%h exp=%h", dut_out(), 12'h000);
      else n_pass++;
      cycle(0, 1, 0);
      for (int i = 0; i < 9; i++) begin
         cycle(1, 0, 0);
         n_checks++;
         if (dut_out() !== model_out()) $display("FAIL abort_restart i=%0d got=%h exp=%h", i, dut_out(), model_out());
         else n_pass++;
         if (o_frame_done) fd_n++;
      end
      n_checks++;
      if (fd_n !== 1) $display("FAIL abort_restart_done got=%0d exp=1", fd_n);
      else n_pass++;
   endtask

   task automatic test_async_reset();
      bit_len = 4'd7; word_len = 3'd1;
      cycle(0, 1, 0);
      repeat (4) cycle(1, 0, 0);
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (dut_out() !== 12'h000) $display("FAIL async_reset got=%h exp=%h", dut_out(), 12'h000);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      cycle(1, 0, 0);
      n_checks++;
      if (dut_out() !== model_out()) $display("FAIL async_reset_release got=%h exp=%h", dut_out(), model_out());
      else n_pass++;
   endtask

   task automatic test_start_controls();
      bit_len = 4'd3; word_len = 3'd0;
      cycle(0, 1, 0);
      repeat (2) cycle(1, 0, 0);
      bit_len = 4'd15; word_len = 3'd5;
      for (int i = 0; i < 4; i++) begin
         cycle(1, 1, 0);
         n_checks++;
         if (dut_out() !== model_out()) $display("FAIL start_busy i=%0d got=%h exp=%h", i, dut_out(), model_out());
         else n_pass++;
      end
      cycle(0, 0, 0);
      cycle(1, 1, 1);
      n_checks++;
      if (o_busy !== 1'b0) $display("FAIL start_with_abort busy got=%b exp=0", o_busy);
      else n_pass++;
   endtask

   task automatic test_zero_len();
      bit_len = 4'd0; word_len = 3'd0;
      cycle(0, 1, 0);
      cycle(0, 0, 0);
      n_checks++;
      if (o_last_bit !== 1'b1 || o_busy !== 1'b1)
         $display("FAIL zero_len_last_bit got last=%b busy=%b exp=1,1", o_last_bit, o_busy);
      else n_pass++;
      cycle(1, 0, 0);
      n_checks++;
      if (dut_out() !== 12'h300) $display("FAIL zero_len_done got=%h exp=%h", dut_out(), 12'h300);
      else n_pass++;
   endtask

`ifdef SPI_FRAME_CNT_GAP_EN
   task automatic test_gap();
      int gap_n = 0, fd_at = -1;
      bit_len = 4'd1; word_len = 3'd1; gap_len = 2'd2;
      cycle(0, 1, 0);
      for (int i = 0; i < 8; i++) begin
         cycle(1, 0, 0);
         n_checks++;
         if (dut_out() !== model_out()) $display("FAIL gap i=%0d got=%h exp=%h", i, dut_out(), model_out());
         else n_pass++;
         if (dut_gap) gap_n++;
         if (o_frame_done) fd_at = i + 1;
      end
      n_checks++;
      if (gap_n !== 2 || fd_at !== 6) $display("FAIL gap_counts gap=%0d at=%0d exp gap=2 at=6", gap_n, fd_at);
      else n_pass++;
      gap_len = 2'd0;
   endtask
`endif

   task automatic test_random();
      bit tk, st, ab;
      for (int i = 0; i < 3000; i++) begin
         bit_len = 4'($urandom_range(0, 5));
         word_len = 3'($urandom_range(0, 3));
         gap_len = 2'($urandom_range(0, 3));
         tk = ($urandom_range(0, 3) != 0);
         st = ($urandom_range(0, 7) == 0);
         ab = ($urandom_range(0, 79) == 0);
         cycle(tk, st, ab);
         n_checks++;
         if (dut_out() !== model_out()) $display("FAIL random i=%0d got=%h exp=%h", i, dut_out(), model_out());
         else n_pass++;
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_single_word();
      test_multi_word();
      test_abort();
      test_async_reset();
      test_start_controls();
      test_zero_len();
`ifdef SPI_FRAME_CNT_GAP_EN
      test_gap();
`endif
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
